multi_word_adder_sequencer: RTL and testbench



---
 rtl/adder_pkg.sv | 17 +
 rtl/multi_word_adder_sequencer_if.sv | 29 ++
 rtl/ripple_carry_adder_4_bit.sv | 24 ++
 rtl/multi_word_adder_sequencer.sv | 109 ++++++++++
 tb/tb_multi_word_adder_sequencer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_pkg;

    localparam int unsigned NIBBLE_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Nibble counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/multi_word_adder_sequencer_if.sv
// Start/busy/done request bus for the nibble-serial adder sequencer.
interface multi_word_adder_sequencer_if
    import adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIBBLE_WIDTH * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );

endinterface

// File: rtl/ripple_carry_adder_4_bit.sv
// Combinational 4-bit ripple-carry adder.
module ripple_carry_adder_4_bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_WIDTH-1:0] a,
    input  logic [NIBBLE_WIDTH-1:0] b,
    input  logic                    carry_in,
    output logic [NIBBLE_WIDTH-1:0] sum,
    output logic                    carry_out
);

    logic carry;

    always_comb begin
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < int'(NIBBLE_WIDTH); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        carry_out = carry;
    end

endmodule

// File: rtl/multi_word_adder_sequencer.sv
// Adds two NIBBLES-wide words through one shared 4-bit adder, one nibble per cycle,
// least-significant nibble first.
module multi_word_adder_sequencer
    import adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input logic                         clk,
    input logic                         reset,
    multi_word_adder_sequencer_if.slave bus
);

    localparam int unsigned W     = NIBBLE_WIDTH * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    logic [NIBBLE_WIDTH-1:0] nib_a, nib_b, nib_sum;
    logic                    nib_carry;

    assign nib_a = a_q[idx_q * NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign nib_b = b_q[idx_q * NIBBLE_WIDTH +: NIBBLE_WIDTH];

    ripple_carry_adder_4_bit u_adder (
        .a         (nib_a),
        .b         (nib_b),
        .carry_in  (carry_q),
        .sum       (nib_sum),
        .carry_out (nib_carry)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.carry_in;
                    idx_d   = '0;
                end
            end
            StRun: begin
                sum_d[idx_q * NIBBLE_WIDTH +: NIBBLE_WIDTH] = nib_sum;
                carry_d = nib_carry;
                if (idx_q == IDX_LAST) begin
                    state_d     = StDone;
                    carry_out_d = nib_carry;
                    // The top nibble is being written this cycle, so its MSB is the final sign.
                    overflow_d  = (a_q[W-1] == b_q[W-1]) && (nib_sum[NIBBLE_WIDTH-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_multi_word_adder_sequencer.sv
// Directed bench for the nibble-serial adder sequencer (NIBBLES = 4).
module tb_multi_word_adder_sequencer;

    localparam int unsigned NIBBLES = 4;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    multi_word_adder_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    multi_word_adder_sequencer #(.NIBBLES(NIBBLES)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble the inputs, then time and check the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum,
                          input logic exp_co, input logic exp_ov);
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.a        = ~a;
        bus.b        = a ^ 16'h5A5A;
        bus.carry_in = ~cin;
        check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done latency"}, n, NIBBLES);
        check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, " carry_out"}, 32'(bus.carry_out), 32'(exp_co));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ov));
        @(negedge clk);
        check({tag, " done one pulse"}, 32'(bus.done), 32'd0);
        check({tag, " idle after done"}, 32'(bus.busy), 32'd0);
        check({tag, " sum held"}, 32'(bus.sum), 32'(exp_sum));
    endtask

    logic [15:0] ra [0:31];
    logic [15:0] rb [0:31];
    logic        rc [0:31];

    initial begin
        logic [16:0] full;
        logic [15:0] es;
        logic        eo;
        int          k, dones;

        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset carry_out", 32'(bus.carry_out), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        @(negedge clk);
        check("reset beats start", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;

        run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("cin",      16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start held high with new operands every cycle: accepts land on
        // edges 0, 6, 12 and their done pulses show at iterations 5, 11, 17.
        for (int j = 0; j < 32; j++) begin
            ra[j] = 16'(16'h1000 * j + 16'h0F0F + j);
            rb[j] = 16'(16'h0101 * (j + 1) + 16'hE000);
            rc[j] = j[0];
        end
        dones = 0;
        for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            if (j >= 5 && (j - 5) % 6 == 0) begin
                k    = j - 5;
                full = {1'b0, ra[k]} + {1'b0, rb[k]} + 17'(rc[k]);
                es   = full[15:0];
                eo   = (ra[k][15] == rb[k][15]) && (es[15] != ra[k][15]);
                check($sformatf("hold done @%0d", j), 32'(bus.done), 32'd1);
                check($sformatf("hold sum @%0d", j), 32'(bus.sum), 32'(es));
                check($sformatf("hold carry_out @%0d", j), 32'(bus.carry_out), 32'(full[16]));
                check($sformatf("hold overflow @%0d", j), 32'(bus.overflow), 32'(eo));
            end else if (j > 0) begin
                check($sformatf("hold no done @%0d", j), 32'(bus.done), 32'd0);
            end
            if (bus.done) dones++;
            bus.start    = 1'b1;
            bus.a        = ra[j];
            bus.b        = rb[j];
            bus.carry_in = rc[j];
        end
        check("hold done count", dones, 3);
        bus.start = 1'b0;
        // Let the operation accepted at edge 18 drain.
        repeat (8) @(negedge clk);
        check("hold drained", 32'(bus.busy), 32'd0);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort sum", 32'(bus.sum), 32'd0);
        check("abort carry_out", 32'(bus.carry_out), 32'd0);
        check("abort overflow", 32'(bus.overflow), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort stays idle", 32'(bus.busy | bus.done), 32'd0);
        end
        run_op("post abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
